// File: rtl/render_sequencer_pkg.sv
// Shared types for the render command sequencer: opcodes, FSM states and the queued command entry.
package render_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_CLEAR = 3'b000,
        OP_DRAW  = 3'b110,
        OP_FLIP  = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_LINE,
        WAIT_CLEAR,
        WAIT_VSYNC
    } state_e;

    // {x[8:0], y[7:0]}
    typedef logic [16:0] point_t;

    typedef struct packed {
        op_e         op;
        point_t      start;
        point_t      end1;
        logic [23:0] color;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    function automatic logic is_queueable(input logic [2:0] code);
        return (code == OP_CLEAR) || (code == OP_DRAW) || (code == OP_FLIP);
    endfunction

endpackage

// File: rtl/render_sequencer_cmd_fifo.sv
// Synchronous command FIFO; writes while full are discarded, reads present the head combinationally.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Depth is a power of two, so pointer wrap is the natural rollover.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/render_sequencer.sv
// Queues clear/draw/flip commands and launches the line and clear engines strictly in arrival order.
//   state      | meaning
//   IDLE       | waiting for a queued command; pops and latches it
//   LAUNCH     | issues the engine go pulse for the latched command
//   WAIT_LINE  | line engine busy until line_done
//   WAIT_CLEAR | clear engine busy until clear_done
//   WAIT_VSYNC | flip pending; swaps buffers on the next vsync
module render_sequencer
    import render_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        received_op,
    input  logic [2:0]  op,
    input  logic [16:0] start,
    input  logic [16:0] end1,
    input  logic [23:0] color,
    input  logic        line_done,
    input  logic        clear_done,
    input  logic        vsync,
    output logic        line_go,
    output logic        clear_go,
    output logic [16:0] line_start,
    output logic [16:0] line_end,
    output logic [23:0] draw_color,
    output logic        front_buf,
    output logic        draw_buf,
    output logic        render_enable,
    output logic        fifo_full,
    output logic        overflow
);
    state_e                       state;
    state_e                       state_nxt;
    cmd_t                         wr_cmd;
    cmd_t                         head;
    op_e                          cur_op;
    logic                         push;
    logic                         pop;
    logic                         fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;
    logic                         line_go_nxt;
    logic                         clear_go_nxt;
    logic                         flip;

    assign push   = received_op && is_queueable(op);
    assign wr_cmd = '{op: op_e'(op), start: start, end1: end1, color: color};

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wr_cmd),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign draw_buf      = ~front_buf;
    assign render_enable = (fifo_count != '0) || (state != IDLE);

    always_comb begin
        state_nxt    = state;
        pop          = 1'b0;
        line_go_nxt  = 1'b0;
        clear_go_nxt = 1'b0;
        flip         = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                case (cur_op)
                    OP_DRAW: begin
                        line_go_nxt = 1'b1;
                        state_nxt   = WAIT_LINE;
                    end
                    OP_CLEAR: begin
                        clear_go_nxt = 1'b1;
                        state_nxt    = WAIT_CLEAR;
                    end
                    default: state_nxt = WAIT_VSYNC;
                endcase
            end
            // A done coincident with our own go pulse belongs to an earlier job.
            WAIT_LINE:  if (line_done && !line_go)   state_nxt = IDLE;
            WAIT_CLEAR: if (clear_done && !clear_go) state_nxt = IDLE;
            WAIT_VSYNC: begin
                if (vsync) begin
                    flip      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cur_op     <= OP_CLEAR;
            line_go    <= 1'b0;
            clear_go   <= 1'b0;
            line_start <= '0;
            line_end   <= '0;
            draw_color <= '0;
            front_buf  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state    <= state_nxt;
            line_go  <= line_go_nxt;
            clear_go <= clear_go_nxt;
            if (pop) begin
                cur_op     <= head.op;
                line_start <= head.start;
                line_end   <= head.end1;
                draw_color <= head.color;
            end
            if (flip) front_buf <= ~front_buf;
            // Full is judged before any same-cycle pop, so the entry is dropped.
            if (push && fifo_full) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_render_sequencer.sv
// Bench for render_sequencer: directed scenarios plus random command bursts against a queue model.
module tb_render_sequencer;
    import render_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        received_op;
    logic [2:0]  op;
    logic [16:0] start;
    logic [16:0] end1;
    logic [23:0] color;
    logic        line_done;
    logic        clear_done;
    logic        vsync;
    logic        line_go;
    logic        clear_go;
    logic [16:0] line_start;
    logic [16:0] line_end;
    logic [23:0] draw_color;
    logic        front_buf;
    logic        draw_buf;
    logic        render_enable;
    logic        fifo_full;
    logic        overflow;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0]  op;
        logic [16:0] s;
        logic [16:0] e;
        logic [23:0] c;
    } mcmd_t;

    mcmd_t model_q[$];
    logic  model_front;

    always #5 clk = ~clk;

    render_sequencer #(.FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .received_op   (received_op),
        .op            (op),
        .start         (start),
        .end1          (end1),
        .color         (color),
        .line_done     (line_done),
        .clear_done    (clear_done),
        .vsync         (vsync),
        .line_go       (line_go),
        .clear_go      (clear_go),
        .line_start    (line_start),
        .line_end      (line_end),
        .draw_color    (draw_color),
        .front_buf     (front_buf),
        .draw_buf      (draw_buf),
        .render_enable (render_enable),
        .fifo_full     (fifo_full),
        .overflow      (overflow)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] o, input logic [16:0] s, input logic [16:0] e, input logic [23:0] c);
        op = o; start = s; end1 = e; color = c; received_op = 1'b1;
        tick;
        received_op = 1'b0;
    endtask

    task automatic pulse_line_done;  line_done = 1'b1;  tick; line_done = 1'b0;  endtask
    task automatic pulse_clear_done; clear_done = 1'b1; tick; clear_done = 1'b0; endtask
    task automatic pulse_vsync;      vsync = 1'b1;      tick; vsync = 1'b0;      endtask

    task automatic no_go(input int n, input string tag);
        logic seen;
        seen = 1'b0;
        repeat (n) begin
            tick;
            seen = seen | line_go | clear_go;
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    task automatic wait_go;
        for (int i = 0; i < 12; i++) begin
            if (line_go || clear_go) break;
            tick;
        end
    endtask

    // Executes the oldest modelled command and checks what the DUT does with it.
    task automatic service_next(input string tag);
        mcmd_t h;
        h = model_q.pop_front();
        if (h.op == 3'b111) begin
            repeat (4) tick;
            pulse_vsync;
            model_front = ~model_front;
            chk({tag, "_flip"}, 64'({front_buf, draw_buf}), 64'({model_front, ~model_front}));
        end else begin
            wait_go;
            chk({tag, "_go"}, 64'({line_go, clear_go}), (h.op == 3'b110) ? 64'd2 : 64'd1);
            chk({tag, "_params"}, 64'({line_start, line_end, draw_color}), 64'({h.s, h.e, h.c}));
            repeat ($urandom_range(1, 3)) tick;
            if (h.op == 3'b110) pulse_line_done;
            else pulse_clear_done;
        end
    endtask

    initial begin
        mcmd_t m;
        logic [2:0] rop;
        int r;
        rst = 1'b1; received_op = 1'b0; op = '0; start = '0; end1 = '0; color = '0;
        line_done = 1'b0; clear_done = 1'b0; vsync = 1'b0;
        model_front = 1'b0;

        #3;
        chk("reset_flags", 64'({line_go, clear_go, front_buf, draw_buf, render_enable, fifo_full, overflow}), 64'b0001000);
        tick;
        rst = 1'b0;
        tick;
        chk("reset_params", 64'({line_start, line_end, draw_color}), 64'd0);

        // Single draw: exact launch latency and parameters
        send(3'b110, 17'd0, {9'd319, 8'd239}, 24'hFF0000);
        chk("lat_k", 64'(line_go), 64'd0);
        tick;
        chk("lat_k1", 64'(line_go), 64'd0);
        tick;
        chk("lat_k2", 64'(line_go), 64'd1);
        chk("draw_params", 64'({line_start, line_end, draw_color}), 64'({17'd0, 9'd319, 8'd239, 24'hFF0000}));
        line_done = 1'b1;
        tick;
        line_done = 1'b0;
        chk("go_one_cycle", 64'(line_go), 64'd0);
        chk("done_with_go_ignored", 64'(render_enable), 64'd1);
        tick;
        pulse_line_done;
        chk("draw_complete", 64'(render_enable), 64'd0);

        // Ignored opcodes and spurious vsync in IDLE
        send(3'b001, 17'h1, 17'h2, 24'h3);
        chk("ignored_001", 64'({render_enable, fifo_full, overflow}), 64'd0);
        send(3'b100, 17'h4, 17'h5, 24'h6);
        chk("ignored_100", 64'({render_enable, fifo_full, overflow}), 64'd0);
        no_go(6, "ignored_no_go");
        pulse_vsync;
        chk("vsync_idle", 64'({front_buf, render_enable}), 64'd0);

        // Ordering: clear, draw, flip back to back
        send(3'b000, 17'h00010, 17'h00020, 24'h00AA55);
        send(3'b110, 17'h01234, 17'h05678, 24'h123456);
        send(3'b111, 17'h0, 17'h0, 24'h0);
        chk("ord_clear_go", 64'({line_go, clear_go}), 64'd1);
        chk("ord_clear_color", 64'(draw_color), 64'h00AA55);
        tick;
        pulse_line_done;
        pulse_vsync;
        no_go(3, "ord_wrong_done_ignored");
        chk("ord_front_hold1", 64'(front_buf), 64'd0);
        pulse_clear_done;
        wait_go;
        chk("ord_line_go", 64'({line_go, clear_go}), 64'd2);
        chk("ord_line_params", 64'({line_start, line_end, draw_color}), 64'({17'h01234, 17'h05678, 24'h123456}));
        tick;
        pulse_clear_done;
        pulse_vsync;
        repeat (4) tick;
        chk("ord_front_hold2", 64'({front_buf, render_enable}), 64'd1);
        pulse_line_done;
        repeat (4) tick;
        chk("ord_front_hold3", 64'(front_buf), 64'd0);
        pulse_vsync;
        chk("ord_flip", 64'({front_buf, draw_buf, render_enable}), 64'b100);
        model_front = 1'b1;

        // Random bursts against the queue model
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < int'($urandom_range(1, 4)); i++) begin
                r = int'($urandom_range(0, 9));
                rop = (r < 3) ? 3'b000 : (r < 6) ? 3'b110 : (r < 8) ? 3'b111 : 3'($urandom_range(1, 5));
                m.op = rop;
                m.s  = 17'($urandom);
                m.e  = 17'($urandom);
                m.c  = 24'($urandom);
                send(m.op, m.s, m.e, m.c);
                if (is_queueable(rop)) model_q.push_back(m);
            end
            while (model_q.size() > 0) service_next($sformatf("rand%0d", b));
            tick;
            chk($sformatf("rand%0d_idle", b), 64'({render_enable, overflow}), 64'd0);
        end

        // Overflow: one in flight, four queued, sixth draw dropped during a pop
        for (int i = 1; i <= 5; i++) begin
            m.op = 3'b110; m.s = 17'(i * 3); m.e = 17'(i); m.c = 24'(i * 24'h010101);
            send(m.op, m.s, m.e, m.c);
            if (i > 1) model_q.push_back(m);
        end
        chk("ovf_full", 64'({fifo_full, overflow}), 64'b10);
        line_done = 1'b1;
        tick;
        line_done = 1'b0;
        send(3'b110, 17'h0ABCD, 17'h1ABCD, 24'hDEAD00);
        chk("ovf_drop", 64'({fifo_full, overflow}), 64'b01);
        while (model_q.size() > 0) service_next("ovf");
        no_go(10, "ovf_dropped_never_runs");
        chk("ovf_sticky", 64'({render_enable, overflow}), 64'b01);

        // Reset in WAIT_LINE with two queued
        send(3'b110, 17'h1, 17'h2, 24'h3);
        send(3'b110, 17'h4, 17'h5, 24'h6);
        send(3'b110, 17'h7, 17'h8, 24'h9);
        tick;
        tick;
        chk("pre_reset_busy", 64'(render_enable), 64'd1);
        rst = 1'b1;
        #2;
        chk("mid_reset_flags", 64'({line_go, clear_go, front_buf, draw_buf, render_enable, fifo_full, overflow}), 64'b0001000);
        chk("mid_reset_params", 64'({line_start, line_end, draw_color}), 64'd0);
        tick;
        rst = 1'b0;
        pulse_line_done;
        no_go(10, "post_reset_no_launch");
        chk("post_reset_idle", 64'({render_enable, fifo_full, front_buf}), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
